jtag_tap_sequencer: RTL and testbench

Command-driven JTAG master that walks an on-chip TAP controller through its state graph by generating TMS/TDI, and captures TDO. Accepts TAP-reset, shift-IR, shift-DR and run-test-idle wait commands over a valid/ready interface, and returns the captured TDO bits on a response channel. Sits between a debug/host engine and the TAP controller; the TAP is clocked by the same clk.

---
 rtl/jtag_pkg.sv | 34 +++
 rtl/jtag_tap_sequencer_shifter.sv | 49 ++++
 rtl/jtag_tap_sequencer.sv | 146 ++++++++++++++
 tb/tb_jtag_tap_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_pkg
// Description : Shared command/state encodings for the JTAG TAP sequencer.
// Revision    : 1.0
// ============================================================================
package jtag_pkg;

  localparam int TLR_TMS_ONES = 5;

  typedef enum logic [1:0] {
    OP_TLR_RESET = 2'd0,
    OP_SHIFT_IR  = 2'd1,
    OP_SHIFT_DR  = 2'd2,
    OP_RTI_WAIT  = 2'd3
  } jtag_op_t;

  // Each state names the TAP state reached on the edge that ends the cycle.
  typedef enum logic [3:0] {
    ST_INIT_TLR = 4'd0,
    ST_IDLE     = 4'd1,
    ST_SEL_DR   = 4'd2,
    ST_SEL_IR   = 4'd3,
    ST_CAPTURE  = 4'd4,
    ST_SHIFT    = 4'd5,
    ST_EXIT1    = 4'd6,
    ST_UPDATE   = 4'd7,
    ST_TLR      = 4'd8,
    ST_RTI_WAIT = 4'd9,
    ST_RESP     = 4'd10
  } jtag_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/jtag_tap_sequencer_shifter.sv
`default_nettype none
// ============================================================================
// Module      : jtag_bit_shifter
// Description : TDI serializer (MSB first) and left-shifting TDO capture.
// Revision    : 1.0
// ============================================================================
module jtag_bit_shifter #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [LEN_WIDTH-1:0]  load_len,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift_out,
  input  logic                  shift_in,
  input  logic                  serial_in,
  output logic                  serial_out,
  output logic [DATA_WIDTH-1:0] captured
);

  localparam logic [LEN_WIDTH-1:0] c_width = LEN_WIDTH'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [LEN_WIDTH-1:0]  w_align;

  // Pre-align so bit len-1 leaves first; capture starts empty so upper bits stay 0.
  assign w_align = c_width - load_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx <= '0;
      r_rx <= '0;
    end else if (load) begin
      r_tx <= load_data << w_align;
      r_rx <= '0;
    end else begin
      if (shift_out) r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
      if (shift_in)  r_rx <= {r_rx[DATA_WIDTH-2:0], serial_in};
    end
  end

  assign serial_out = r_tx[DATA_WIDTH-1];
  assign captured   = r_rx;

endmodule
`default_nettype wire

// File: rtl/jtag_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_sequencer
// Description : Command-driven JTAG master generating registered TMS/TDI.
// Revision    : 1.0
// ============================================================================
module jtag_tap_sequencer
  import jtag_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  tms,
  output logic                  tdi,
  input  logic                  tdo,
  output logic                  busy
);

  localparam logic [LEN_WIDTH-1:0] c_max_len  = LEN_WIDTH'(DATA_WIDTH);
  localparam logic [LEN_WIDTH-1:0] c_tlr_ones = LEN_WIDTH'(TLR_TMS_ONES);
  localparam logic [LEN_WIDTH-1:0] c_one      = LEN_WIDTH'(1);

  jtag_seq_state_t      r_state, w_state_nxt;
  jtag_op_t             r_op, w_op;
  logic [LEN_WIDTH-1:0] r_cnt, w_cnt_nxt, w_len;
  logic                 r_tms, r_tdi, r_cap;
  logic                 w_tms_nxt, w_tdi_nxt, w_accept, w_tx_msb, w_shift;

  assign w_op      = jtag_op_t'(cmd_op);
  assign w_len     = (cmd_len > c_max_len) ? c_max_len : cmd_len;
  assign cmd_ready = (r_state == ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign rsp_valid = (r_state == ST_RESP);
  assign busy      = (r_state != ST_IDLE);
  assign w_shift   = (r_state == ST_SHIFT);
  assign tms       = r_tms;
  assign tdi       = r_tdi;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_INIT_TLR: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
        else             w_cnt_nxt   = r_cnt - c_one;
      end
      ST_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt = w_len;
          if (w_op == OP_TLR_RESET) begin
            w_state_nxt = ST_TLR;
            w_cnt_nxt   = c_tlr_ones;
          end else if (w_len == '0) begin
            w_state_nxt = ST_RESP;
          end else if (w_op == OP_RTI_WAIT) begin
            w_state_nxt = ST_RTI_WAIT;
          end else begin
            w_state_nxt = ST_SEL_DR;
          end
        end
      end
      ST_SEL_DR:  w_state_nxt = (r_op == OP_SHIFT_IR) ? ST_SEL_IR : ST_CAPTURE;
      ST_SEL_IR:  w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        w_cnt_nxt = r_cnt - c_one;
        if (r_cnt == c_one) w_state_nxt = ST_EXIT1;
      end
      ST_EXIT1:   w_state_nxt = ST_UPDATE;
      // Single TMS=0 cycle back into Run-Test/Idle before responding.
      ST_UPDATE: begin
        w_state_nxt = ST_RTI_WAIT;
        w_cnt_nxt   = c_one;
      end
      ST_TLR: begin
        if (r_cnt == c_one) begin
          w_state_nxt = ST_RTI_WAIT;
          w_cnt_nxt   = c_one;
        end else begin
          w_cnt_nxt = r_cnt - c_one;
        end
      end
      ST_RTI_WAIT: begin
        if (r_cnt == c_one) w_state_nxt = ST_RESP;
        else                w_cnt_nxt   = r_cnt - c_one;
      end
      ST_RESP:    if (rsp_ready) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_INIT_TLR;
    endcase

    case (w_state_nxt)
      ST_INIT_TLR: w_tms_nxt = (w_cnt_nxt != '0);
      ST_SEL_DR, ST_SEL_IR, ST_EXIT1, ST_UPDATE, ST_TLR: w_tms_nxt = 1'b1;
      default:     w_tms_nxt = 1'b0;
    endcase

    // Data bits land on the cycles following each SHIFT-state cycle.
    w_tdi_nxt = w_shift && w_tx_msb;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_INIT_TLR;
      r_cnt   <= c_tlr_ones;
      r_op    <= OP_TLR_RESET;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
      r_cap   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tms   <= w_tms_nxt;
      r_tdi   <= w_tdi_nxt;
      r_cap   <= w_shift;
      if (w_accept) r_op <= w_op;
    end
  end

  jtag_bit_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (w_accept),
    .load_len   (w_len),
    .load_data  (cmd_data),
    .shift_out  (w_shift),
    .shift_in   (r_cap),
    .serial_in  (tdo),
    .serial_out (w_tx_msb),
    .captured   (rsp_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_tap_sequencer
// Description : Directed bench with a behavioural TAP controller model.
// Revision    : 1.0
// ============================================================================
module tb_jtag_tap_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        tms, tdi, tdo, busy;

  always #5 clk = ~clk;

  jtag_tap_sequencer #(.DATA_WIDTH(32), .LEN_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy)
  );

  // TAP controller model: 8-bit DR and 4-bit IR, shifted in at the LSB.
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDR,
    T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
  } tap_t;

  tap_t       tap_st = T_SHDR;
  logic [7:0] tap_dr = 8'h00;
  logic [3:0] tap_ir = 4'h0;
  logic       lb = 1'b0;
  logic       loop_mode = 1'b0;
  logic       preset = 1'b0;
  logic [7:0] preset_dr = 8'h00;
  logic [3:0] preset_ir = 4'h0;
  int         upd_total = 0;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      T_TLR:   return m ? T_TLR   : T_RTI;
      T_RTI:   return m ? T_SELDR : T_RTI;
      T_SELDR: return m ? T_SELIR : T_CAPDR;
      T_CAPDR: return m ? T_EX1DR : T_SHDR;
      T_SHDR:  return m ? T_EX1DR : T_SHDR;
      T_EX1DR: return m ? T_UPDR  : T_PADR;
      T_PADR:  return m ? T_EX2DR : T_PADR;
      T_EX2DR: return m ? T_UPDR  : T_SHDR;
      T_UPDR:  return m ? T_SELDR : T_RTI;
      T_SELIR: return m ? T_TLR   : T_CAPIR;
      T_CAPIR: return m ? T_EX1IR : T_SHIR;
      T_SHIR:  return m ? T_EX1IR : T_SHIR;
      T_EX1IR: return m ? T_UPIR  : T_PAIR;
      T_PAIR:  return m ? T_EX2IR : T_PAIR;
      T_EX2IR: return m ? T_UPIR  : T_SHIR;
      T_UPIR:  return m ? T_SELDR : T_RTI;
      default: return T_TLR;
    endcase
  endfunction

  always @(posedge clk) begin
    tap_st <= tap_next(tap_st, tms);
    lb     <= tdi;
    if (preset) begin
      tap_dr <= preset_dr;
      tap_ir <= preset_ir;
    end else begin
      if (tap_st == T_SHDR) tap_dr <= {tap_dr[6:0], tdi};
      if (tap_st == T_SHIR) tap_ir <= {tap_ir[2:0], tdi};
      if (tap_st == T_TLR)  tap_ir <= 4'h1;
    end
    if (tap_st == T_UPDR || tap_st == T_UPIR) upd_total <= upd_total + 1;
  end

  assign tdo = loop_mode ? lb :
               (tap_st == T_SHDR) ? tap_dr[7] :
               (tap_st == T_SHIR) ? tap_ir[3] : 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called on a negedge in IDLE; returns on the negedge of the first cycle after accept.
  task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
    check("cmd_ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    logic ok;
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      cyc++;
      @(negedge clk);
    end
    check("rsp_within_budget", ok, 1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drops", rsp_valid, 0);
    check("cmd_ready_after_rsp", cmd_ready, 1);
  endtask

  // Caller releases reset just after a posedge; samples cycles 1..7 then 5 idle cycles.
  task automatic check_init(input string tag);
    logic [6:0] tms_tr;
    logic [6:0] rdy_tr;
    logic       saw_rsp;
    tms_tr  = '0;
    rdy_tr  = '0;
    saw_rsp = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      tms_tr  = {tms_tr[5:0], tms};
      rdy_tr  = {rdy_tr[5:0], cmd_ready};
      saw_rsp = saw_rsp | rsp_valid;
    end
    check({tag, "_tms_seq"}, tms_tr, 7'b1111100);
    check({tag, "_ready_seq"}, rdy_tr, 7'b0000001);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tap_rti"}, tap_st == T_RTI, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      saw_rsp = saw_rsp | rsp_valid;
    end
    check({tag, "_no_rsp"}, saw_rsp, 0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] data;
    logic        loop;
    logic [7:0]  pdr;
    logic [3:0]  pir;
    int          cyc;
    logic [31:0] rsp;
    logic [7:0]  exp_reg;
    int          upd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int cyc;
    int upd0;
    logic [9:0] tms_tr;

    //               op    len    data           loop  pdr    pir   cyc rsp            reg    upd
    vecs[0]  = '{2'd2, 6'd8,  32'h0000_00A5, 1'b0, 8'h3C, 4'h1, 13, 32'h0000_003C, 8'hA5, 1};
    vecs[1]  = '{2'd1, 6'd4,  32'h0000_0009, 1'b0, 8'h00, 4'h6, 10, 32'h0000_0006, 8'h09, 1};
    vecs[2]  = '{2'd2, 6'd40, 32'hDEAD_BEEF, 1'b1, 8'h00, 4'h0, 37, 32'h6F56_DF77, 8'hEF, 1};
    vecs[3]  = '{2'd2, 6'd0,  32'hFFFF_FFFF, 1'b0, 8'h11, 4'h0, 0,  32'h0000_0000, 8'h11, 0};
    vecs[4]  = '{2'd3, 6'd3,  32'h0000_0000, 1'b0, 8'h22, 4'h0, 3,  32'h0000_0000, 8'h22, 0};
    vecs[5]  = '{2'd0, 6'd7,  32'h0000_0000, 1'b0, 8'h33, 4'h0, 6,  32'h0000_0000, 8'h33, 0};
    vecs[6]  = '{2'd2, 6'd1,  32'h0000_0001, 1'b0, 8'h80, 4'h0, 6,  32'h0000_0001, 8'h01, 1};
    vecs[7]  = '{2'd1, 6'd0,  32'h0000_000F, 1'b0, 8'h00, 4'h5, 0,  32'h0000_0000, 8'h05, 0};
    vecs[8]  = '{2'd2, 6'd32, 32'h1234_5678, 1'b0, 8'hAB, 4'h0, 37, 32'hAB12_3456, 8'h78, 1};
    vecs[9]  = '{2'd3, 6'd40, 32'h0000_0000, 1'b0, 8'h44, 4'h0, 32, 32'h0000_0000, 8'h44, 0};
    vecs[10] = '{2'd1, 6'd4,  32'h0000_000C, 1'b0, 8'h00, 4'h3, 10, 32'h0000_0003, 8'h0C, 1};

    repeat (3) @(negedge clk);
    check("reset_outputs", {tms, tdi, cmd_ready, rsp_valid, busy, rsp_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0});
    @(posedge clk);
    #1 reset = 1'b0;
    check_init("init");

    for (int v = 0; v < 11; v++) begin
      preset_dr = vecs[v].pdr;
      preset_ir = vecs[v].pir;
      loop_mode = vecs[v].loop;
      preset    = 1'b1;
      @(negedge clk);
      preset = 1'b0;
      upd0   = upd_total;
      issue(vecs[v].op, vecs[v].len, vecs[v].data);
      wait_rsp(cyc);
      check($sformatf("v%0d_cycles", v), cyc, vecs[v].cyc);
      check($sformatf("v%0d_rsp_data", v), rsp_data, vecs[v].rsp);
      check($sformatf("v%0d_tap_rti", v), tap_st == T_RTI, 1);
      check($sformatf("v%0d_tap_reg", v),
            (vecs[v].op == 2'd1) ? {4'h0, tap_ir} : tap_dr, vecs[v].exp_reg);
      check($sformatf("v%0d_updates", v), upd_total - upd0, vecs[v].upd);
      handshake();
    end

    // IR shift TMS waveform
    loop_mode = 1'b0;
    issue(2'd1, 6'd4, 32'h9);
    tms_tr = {9'd0, tms};
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      tms_tr = {tms_tr[8:0], tms};
    end
    check("ir_tms_seq", tms_tr, 10'b1100000110);
    wait_rsp(cyc);
    check("ir_tap_reg", tap_ir, 4'h9);
    handshake();

    // Response backpressure with a competing command pending
    preset_dr = 8'h96;
    preset_ir = 4'h0;
    preset    = 1'b1;
    @(negedge clk);
    preset = 1'b0;
    issue(2'd2, 6'd8, 32'h77);
    wait_rsp(cyc);
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_len   = 6'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", k), {rsp_valid, tms, cmd_ready, rsp_data},
            {1'b1, 1'b0, 1'b0, 32'h96});
    end
    cmd_valid = 1'b0;
    handshake();

    // Reset on the third shift cycle of a DR shift
    issue(2'd2, 6'd8, 32'hA5);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_outputs", {tms, tdi, rsp_valid, cmd_ready, busy},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_init("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
